// File: rtl/vote_round_controller.sv
// rtl/vote_round_controller.sv - 2-of-3 majority voting round sequencer
// Collects three ballots per round, evaluates pair/triple, hands result off over valid/ready.
module vote_round_controller #(
  parameter int MAX_COUNT = 10_000_000,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       vote_valid,
  input  logic [2:0]       vote_data,
  output logic [2:0]       vote_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_pair,
  output logic             res_triple,
  output logic             res_timeout,
  output logic [2:0]       res_mask,
  output logic [CNT_W-1:0] pass_count
);
  localparam int TW = $clog2(MAX_COUNT + 1);

  typedef enum logic [1:0] {COLLECT, EVAL, RESULT} state_t;

  state_t        state, state_nxt;
  logic [2:0]    mask, mask_nxt, ballot, accept, eff;
  logic [TW-1:0] timer, timer_nxt;

  assign vote_ready = (state == COLLECT) ? ~mask : 3'b000;
  assign accept     = vote_valid & vote_ready;
  assign mask_nxt   = mask | accept;
  // Timer stays idle at 0 until the first ballot of the round lands.
  assign timer_nxt  = (timer != '0 || accept != '0) ? timer + 1'b1 : timer;
  assign eff        = ballot & mask;

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // Looking at the incremented timer lets EVAL begin exactly when it reaches MAX_COUNT.
      COLLECT: if (&mask_nxt || timer_nxt == TW'(MAX_COUNT)) state_nxt = EVAL;
      EVAL:    state_nxt = RESULT;
      RESULT:  if (res_valid && res_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask        <= '0;
      ballot      <= '0;
      timer       <= '0;
      res_valid   <= 1'b0;
      res_pair    <= 1'b0;
      res_triple  <= 1'b0;
      res_timeout <= 1'b0;
      res_mask    <= '0;
      pass_count  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          mask   <= mask_nxt;
          timer  <= timer_nxt;
          ballot <= (ballot & ~accept) | (vote_data & accept);
        end
        EVAL: begin
          res_pair    <= ((eff[0] | eff[1]) & eff[2]) | (eff[0] & eff[1]);
          res_triple  <= &eff;
          res_timeout <= ~&mask;
          res_mask    <= mask;
          res_valid   <= 1'b1;
        end
        RESULT: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            mask      <= '0;
            ballot    <= '0;
            timer     <= '0;
            if (res_pair && pass_count != '1) pass_count <= pass_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
